sar_search_4bit: RTL and testbench



---
 rtl/sar_pkg.sv | 17 +
 rtl/sar_search_4bit_if.sv | 26 ++
 rtl/sar_search_4bit.sv | 106 ++++++++++
 tb/tb_sar_search_4bit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

    localparam int SAR_WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } sar_state_e;

    // A consistent comparator asserts exactly one of its three flags.
    function automatic logic flags_one_hot(input logic gt, input logic eq, input logic lt);
        return (gt & ~eq & ~lt) | (~gt & eq & ~lt) | (~gt & ~eq & lt);
    endfunction

endpackage

// File: rtl/sar_search_4bit_if.sv
// Comparator-side bus: the controller drives the trial value (comparator ain)
// and reads back the three magnitude flags.
interface sar_search_4bit_if
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF
);
    logic [WIDTH-1:0] trial;
    logic             a_greater;
    logic             a_b_equal;
    logic             b_greater;

    modport master (
        output trial,
        input  a_greater,
        input  a_b_equal,
        input  b_greater
    );

    modport slave (
        input  trial,
        output a_greater,
        output a_b_equal,
        output b_greater
    );
endinterface

// File: rtl/sar_search_4bit.sv
// Successive-approximation search controller. Finds an unknown value that is
// only observable through an external magnitude comparator.
// Optional build macro: SAR_EARLY_EXIT_EN (finish as soon as equality is seen).
//
// state  | meaning
// IDLE   | waiting for start
// SEARCH | one bit decided per cycle, MSB first
// DONE   | result/err valid, done pulses for one cycle
module sar_search_4bit
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    sar_search_4bit_if.master cmp,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              err
);

    sar_state_e       state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] kept;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            trial_q  <= '0;
            mask_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            mask_q   <= mask_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Next-state and next-datapath decode; mask_q marks the bit under test.
    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        mask_d   = mask_q;
        result_d = result_q;
        err_d    = err_q;
        kept     = trial_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEARCH;
                    mask_d  = {1'b1, {(WIDTH-1){1'b0}}};
                    trial_d = {1'b1, {(WIDTH-1){1'b0}}};
                    err_d   = 1'b0;
                end
            end

            ST_SEARCH: begin
                if (cmp.a_greater)
                    kept = trial_q & ~mask_q;

                if (!flags_one_hot(cmp.a_greater, cmp.a_b_equal, cmp.b_greater)) begin
                    err_d    = 1'b1;
                    result_d = trial_q;
                    state_d  = ST_DONE;
`ifdef SAR_EARLY_EXIT_EN
                end else if (cmp.a_b_equal) begin
                    result_d = trial_q;
                    state_d  = ST_DONE;
`endif
                end else if (mask_q[0]) begin
                    trial_d  = kept;
                    result_d = kept;
                    state_d  = ST_DONE;
                end else begin
                    trial_d = kept | (mask_q >> 1);
                    mask_d  = mask_q >> 1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmp.trial = trial_q;
    assign busy      = (state_q == ST_SEARCH);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sar_search_4bit.sv
// Self-checking bench for sar_search_4bit: a behavioural comparator supplies the
// flags and a binary-search model predicts trials, latency and result.
module tb_sar_search_4bit;
    import sar_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err;
    logic [W-1:0] target;
    logic         kill_flags;

    int checks;
    int failures;

    sar_search_4bit_if #(.WIDTH(W)) cmp_if ();

    // Behavioural comparator; kill_flags models a broken comparator (no flag set).
    assign cmp_if.a_greater = !kill_flags && (cmp_if.trial >  target);
    assign cmp_if.a_b_equal = !kill_flags && (cmp_if.trial == target);
    assign cmp_if.b_greater = !kill_flags && (cmp_if.trial <  target);

    sar_search_4bit #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .cmp    (cmp_if.master),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain binary search over the value range, MSB first.
    task automatic model(input int tgt, output int trials[$], output int res);
        int acc;
        int t;
        acc = 0;
        trials = {};
        for (int b = W - 1; b >= 0; b--) begin
            t = acc | (1 << b);
            trials.push_back(t);
`ifdef SAR_EARLY_EXIT_EN
            if (t == tgt) begin
                acc = t;
                break;
            end
`endif
            if (t <= tgt) acc = t;
        end
        res = acc;
    endtask

    // Entered just after a rising edge; returns just after a rising edge.
    task automatic run_search(input string name, input logic [W-1:0] tgt);
        int trials[$];
        int res;
        int lat;
        model(int'(tgt), trials, res);
        lat = trials.size() + 1;
        target = tgt;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                chk({name, "_busy"},  busy,  1);
                chk({name, "_done0"}, done,  0);
                chk({name, "_trial"}, cmp_if.trial, trials[c-1]);
            end else begin
                chk({name, "_done"},   done,   1);
                chk({name, "_idle"},   busy,   0);
                chk({name, "_result"}, result, res);
                chk({name, "_eqtgt"},  result, tgt);
                chk({name, "_err"},    err,    0);
            end
        end
        @(negedge clk);
        chk({name, "_pulse"}, done, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] rnd;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        start      = 1'b0;
        target     = '0;
        kill_flags = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_trial",  cmp_if.trial, 0);
        chk("rst_result", result, 0);
        chk("rst_busy",   busy,   0);
        chk("rst_done",   done,   0);
        chk("rst_err",    err,    0);
        @(posedge clk);
        #1;

        // Directed targets.
        run_search("t1011", 4'b1011);
        run_search("t0000", 4'b0000);
        run_search("t1111", 4'b1111);
        run_search("t1000", 4'b1000);

        // Explicit trial sequence for 1011 independent of the model.
        target = 4'b1011;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk); chk("seq_t1", cmp_if.trial, 4'b1000);
        @(negedge clk); chk("seq_t2", cmp_if.trial, 4'b1100);
        @(negedge clk); chk("seq_t3", cmp_if.trial, 4'b1010);
        @(negedge clk); chk("seq_t4", cmp_if.trial, 4'b1011);
        @(negedge clk); chk("seq_done", done, 1);
        chk("seq_result", result, 4'b1011);
        @(posedge clk);
        #1;

        // Random targets.
        for (int i = 0; i < 8; i++) begin
            rnd = W'($urandom_range(0, (1 << W) - 1));
            run_search("rand", rnd);
        end

        // start held high: ignored during SEARCH and DONE, taken in next IDLE.
        target = 4'b0101;
        start  = 1'b1;
        @(posedge clk);
        begin
            int trials[$];
            int res;
            int lat;
            model(5, trials, res);
            lat = trials.size() + 1;
            for (int c = 1; c <= lat; c++) @(negedge clk);
            chk("b2b_done", done, 1);
            chk("b2b_result", result, 4'b0101);
            @(negedge clk);
            chk("b2b_idle_busy", busy, 0);
            @(negedge clk);
            chk("b2b_restart_busy", busy, 1);
            chk("b2b_restart_trial", cmp_if.trial, 4'b1000);
        end
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Broken comparator on the second trial.
        target = 4'b1011;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 kill_flags = 1'b1;
        @(negedge clk);
        chk("err_trial2", cmp_if.trial, 4'b1100);
        @(posedge clk);
        #1 kill_flags = 1'b0;
        @(negedge clk);
        chk("err_done",   done,   1);
        chk("err_flag",   err,    1);
        chk("err_result", result, 4'b1100);
        chk("err_busy",   busy,   0);
        @(negedge clk);
        chk("err_pulse", done, 0);
        chk("err_hold",  err,  1);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("err_clear", err, 0);
        repeat (6) @(posedge clk);
        #1;

        // Reset on the third SEARCH cycle.
        target = 4'b1001;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_trial",  cmp_if.trial, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_busy",   busy,   0);
        chk("mid_rst_done",   done,   0);
        chk("mid_rst_err",    err,    0);
        @(posedge clk);
        #1;

        // rst wins over start in the same cycle.
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        chk("rst_prio_busy", busy, 0);
        @(posedge clk);
        #1;

        run_search("t0110", 4'b0110);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
